// File: rtl/mem_access.sv
// Byte/halfword/word load-store engine in front of a single-port word memory (big-endian lanes).
// Latency: loads and SW finish 3 cycles after acceptance, SB/SH 5 (read-modify-write), rejects 1.
// Backpressure: busy is high while a request is in flight; start is ignored until busy drops.
module mem_access #(
  parameter int DEPTH = 10000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout
);

  localparam logic [2:0] OP_LB = 3'd0, OP_LH = 3'd1, OP_LW = 3'd2, OP_LBU = 3'd3,
                         OP_LHU = 3'd4, OP_SB = 3'd5, OP_SH = 3'd6, OP_SW = 3'd7;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, WREL, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic [31:0] cap_q;
  logic        err_q;

  logic        is_half, is_word, misalign, out_of_range, bad;
  logic        op_q_load;
  logic [31:0] merged, ld_val;

  // Request decode: alignment and range are judged on the live inputs at acceptance.
  always_comb begin
    is_half      = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    is_word      = (op == OP_LW) || (op == OP_SW);
    misalign     = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
    out_of_range = ({2'b00, addr[31:2]} >= DEPTH_W);
    bad          = misalign || out_of_range;
    op_q_load    = (op_q <= OP_LHU);
  end

  // Sub-word store merge: replace only the addressed big-endian lane of the fetched word.
  always_comb begin
    merged = mem_dout;
    if (op_q == OP_SB) begin
      case (off_q)
        2'd0:    merged = {wdata_q[7:0], mem_dout[23:0]};
        2'd1:    merged = {mem_dout[31:24], wdata_q[7:0], mem_dout[15:0]};
        2'd2:    merged = {mem_dout[31:16], wdata_q[7:0], mem_dout[7:0]};
        default: merged = {mem_dout[31:8], wdata_q[7:0]};
      endcase
    end else if (op_q == OP_SH) begin
      merged = off_q[1] ? {mem_dout[31:16], wdata_q[15:0]} : {wdata_q[15:0], mem_dout[15:0]};
    end
  end

  // Load extraction from the captured word with sign or zero extension.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    case (off_q)
      2'd0:    b = cap_q[31:24];
      2'd1:    b = cap_q[23:16];
      2'd2:    b = cap_q[15:8];
      default: b = cap_q[7:0];
    endcase
    h = off_q[1] ? cap_q[15:0] : cap_q[31:16];
    case (op_q)
      OP_LB:   ld_val = {{24{b[7]}}, b};
      OP_LH:   ld_val = {{16{h[15]}}, h};
      OP_LBU:  ld_val = {24'h0, b};
      OP_LHU:  ld_val = {16'h0, h};
      default: ld_val = cap_q;
    endcase
  end

  // State register; reset wins over any pending start.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and strobes; strobes decode straight from state so reset drops them at once.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    err       = (state == DONE) && err_q;
    mem_read  = (state == RD);
    mem_write = (state == WR);
    case (state)
      IDLE: begin
        if (start) begin
          if (bad)              state_nxt = DONE;
          else if (op == OP_SW) state_nxt = WR;
          else                  state_nxt = RD;
        end
      end
      RD:      state_nxt = CAP;
      CAP:     state_nxt = op_q_load ? DONE : WR;
      WR:      state_nxt = WREL;
      WREL:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch the request, capture read data as the read strobe ends, publish loads on entry to DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= OP_LB;
      off_q    <= 2'b00;
      wdata_q  <= 32'h0;
      cap_q    <= 32'h0;
      err_q    <= 1'b0;
      rdata    <= 32'h0;
      mem_addr <= 32'h0;
      mem_din  <= 32'h0;
    end else begin
      if (state == IDLE && start) begin
        op_q     <= op;
        off_q    <= addr[1:0];
        wdata_q  <= wdata;
        err_q    <= bad;
        mem_addr <= {2'b00, addr[31:2]};
        if (!bad && op == OP_SW) mem_din <= wdata;
      end
      if (state == RD) begin
        cap_q <= mem_dout;
        // Merged word is ready one cycle ahead of the write strobe and held through WREL.
        if (op_q == OP_SB || op_q == OP_SH) mem_din <= merged;
      end
      if (state == CAP && op_q_load) rdata <= ld_val;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
  localparam int DEPTH = 64;
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3,
                         LHU = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] addr, wdata;
  logic        busy, done, err, mem_read, mem_write;
  logic [31:0] rdata, mem_addr, mem_din, mem_dout;

  logic [31:0] mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] m_rdata;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_access #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_read(mem_read), .mem_write(mem_write),
    .mem_dout(mem_dout)
  );

  // Bench-side data memory: combinational read, write on the clock edge while the strobe is high.
  assign mem_dout = (mem_addr < DEPTH) ? mem[mem_addr[AW-1:0]] : 32'h0;
  always @(posedge clk) if (mem_write && mem_addr < DEPTH) mem[mem_addr[AW-1:0]] = mem_din;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One request end to end; expected timing and data come from the op's rules, not the FSM.
  task automatic req(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd, input bit hold);
    logic [31:0] widx, old, nw, exp_rd, lane, mask;
    bit bad, ld, sub;
    int lat, sh;
    bit e_rd, e_wr;
    widx = a >> 2;
    bad  = (widx >= DEPTH) || ((o == LH || o == LHU || o == SH) && a[0])
           || ((o == LW || o == SW) && a[1:0] != 2'b00);
    ld   = (o <= LHU);
    sub  = (o == SB || o == SH);
    lat  = bad ? 1 : (sub ? 5 : 3);
    old  = bad ? 32'h0 : ref_mem[widx[AW-1:0]];
    exp_rd = m_rdata;
    nw     = old;
    if (o == LB || o == LBU || o == SB) begin
      sh   = 8 * (3 - int'(a[1:0]));
      mask = 32'hFF << sh;
    end else begin
      sh   = 16 * (1 - int'(a[1]));
      mask = 32'hFFFF << sh;
    end
    lane = (old & mask) >> sh;
    case (o)
      LB:  exp_rd = (lane >= 128) ? lane - 256 : lane;
      LH:  exp_rd = (lane >= 32768) ? lane - 65536 : lane;
      LW:  exp_rd = old;
      LBU, LHU: exp_rd = lane;
      SW:  nw = wd;
      default: nw = (old & ~mask) | ((wd << sh) & mask);
    endcase

    @(negedge clk);
    check("idle_before_start", {30'h0, busy, done}, 32'h0);
    start = 1'b1; op = o; addr = a; wdata = wd;
    for (int cyc = 1; cyc <= lat; cyc++) begin
      @(negedge clk);
      e_rd = !bad && (ld || sub) && cyc == 1;
      e_wr = !bad && ((o == SW && cyc == 1) || (sub && cyc == 3));
      check("ctl{busy,done,err,rd,wr}", {27'h0, busy, done, err, mem_read, mem_write},
            {27'h0, 1'b1, cyc == lat, bad && cyc == lat, e_rd, e_wr});
      if (e_rd || e_wr) check("mem_addr", mem_addr, widx);
      if ((sub && !bad && cyc >= 2 && cyc <= 4) || e_wr) check("mem_din", mem_din, nw);
      if (cyc == lat && !bad && ld) m_rdata = exp_rd;
      check("rdata", rdata, m_rdata);
      if (!hold || cyc == lat) start = 1'b0;
      else begin
        op = 3'($urandom); addr = $urandom; wdata = $urandom;
      end
    end
    if (!bad && !ld) ref_mem[widx[AW-1:0]] = nw;
  endtask

  initial begin
    logic [31:0] v;
    int diff;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    m_rdata = 32'h0;
    // Reset together with start: reset must win.
    reset = 1'b1; start = 1'b1; op = LW; addr = 32'h10; wdata = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_ctl", {27'h0, busy, done, err, mem_read, mem_write}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_mem_din", mem_din, 32'h0);
    reset = 1'b0; start = 1'b0;

    // Directed scenario with hand-computed results.
    req(SW, 32'h10, 32'hDEADBEEF, 1'b0);
    req(LW, 32'h10, 32'h0, 1'b0);
    check("lit_lw_after_sw", rdata, 32'hDEADBEEF);
    req(SB, 32'h11, 32'h55, 1'b1);
    check("lit_mem_after_sb", mem[4], 32'hDE55BEEF);
    req(LW, 32'h10, 32'h0, 1'b0);
    check("lit_lw_after_sb", rdata, 32'hDE55BEEF);
    req(LB, 32'h12, 32'h0, 1'b0);
    check("lit_lb", rdata, 32'hFFFFFFBE);
    req(LBU, 32'h12, 32'h0, 1'b0);
    check("lit_lbu", rdata, 32'h000000BE);
    req(LH, 32'h10, 32'h0, 1'b0);
    check("lit_lh", rdata, 32'hFFFFDE55);
    req(LW, 32'h13, 32'h0, 1'b0);
    check("lit_reject_keeps_rdata", rdata, 32'hFFFFDE55);
    req(SW, 32'(4 * DEPTH), 32'h12345678, 1'b0);
    req(SH, 32'(4 * DEPTH + 1), 32'h12345678, 1'b0);
    req(SH, 32'h16, 32'hAAAA1234, 1'b0);
    check("lit_sh_low_half", mem[5] & 32'h0000FFFF, 32'h00001234);

    // Reset during the write cycle of an SH, with start held high throughout.
    @(negedge clk);
    start = 1'b1; op = SH; addr = 32'h22; wdata = 32'h0000BEEF;
    @(negedge clk);
    check("sh_rd_strobe", {31'h0, mem_read}, 32'h1);
    op = LW; addr = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check("sh_wr_strobe", {31'h0, mem_write}, 32'h1);
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    check("midwr_reset_ctl", {27'h0, busy, done, err, mem_read, mem_write}, 32'h0);
    check("midwr_reset_rdata", rdata, 32'h0);
    check("midwr_reset_mem_addr", mem_addr, 32'h0);
    check("midwr_reset_mem_din", mem_din, 32'h0);
    reset = 1'b0;
    m_rdata = 32'h0;
    // Whether the interrupted write reached the array is the memory's business; resync that word.
    ref_mem[8] = mem[8];
    req(LW, 32'h10, 32'h0, 1'b0);
    check("lit_lw_after_reset", rdata, 32'hDE55BEEF);

    // Randomized traffic, including out-of-range and misaligned requests.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = (32'($urandom_range(0, DEPTH + 2)) << 2) | 32'($urandom_range(0, 3));
      req(3'($urandom_range(0, 7)), a, $urandom, 1'($urandom_range(0, 1)));
    end

    diff = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) diff++;
    check("mem_image_diffs", 32'(diff), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
